// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the I/D memory port arbiter.
package mem_arb_pkg;

  // Transaction phases: wait for a requester, drive the memory, report back.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  // Access sizes as carried on D_SIZE / M_SIZE.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Fields presented to the backing memory for one access.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sign;
  } mem_req_t;

  // Instruction fetches are always plain word reads.
  function automatic mem_req_t ifetch_req(input logic [31:0] addr);
    mem_req_t r;
    r.we    = 1'b0;
    r.addr  = addr;
    r.wdata = 32'h0;
    r.size  = SZ_WORD;
    r.sign  = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and status signals of the arbiter, bundled.
// slave  : arbiter view.
// master : environment view (requesters, memory, observers).
interface mem_port_arbiter_if;

  // Instruction-fetch requester
  logic        I_REQ;
  logic [31:0] I_ADDR;
  logic        I_ACK;
  logic [31:0] I_RDATA;

  // Data-memory requester
  logic        D_REQ;
  logic        D_WE;
  logic [31:0] D_ADDR;
  logic [31:0] D_WDATA;
  logic [1:0]  D_SIZE;
  logic        D_SIGN;
  logic        D_ACK;
  logic [31:0] D_RDATA;

  // Backing memory
  logic        M_REQ;
  logic        M_WE;
  logic [31:0] M_ADDR;
  logic [31:0] M_WDATA;
  logic [1:0]  M_SIZE;
  logic        M_SIGN;
  logic        M_ACK;
  logic [31:0] M_RDATA;

  // Status
  logic        GRANT_D;
  logic        BUSY;
  logic        ERR;

  modport slave (
    input  I_REQ, I_ADDR,
    output I_ACK, I_RDATA,
    input  D_REQ, D_WE, D_ADDR, D_WDATA, D_SIZE, D_SIGN,
    output D_ACK, D_RDATA,
    output M_REQ, M_WE, M_ADDR, M_WDATA, M_SIZE, M_SIGN,
    input  M_ACK, M_RDATA,
    output GRANT_D, BUSY, ERR
  );

  modport master (
    output I_REQ, I_ADDR,
    input  I_ACK, I_RDATA,
    output D_REQ, D_WE, D_ADDR, D_WDATA, D_SIZE, D_SIGN,
    input  D_ACK, D_RDATA,
    input  M_REQ, M_WE, M_ADDR, M_WDATA, M_SIZE, M_SIGN,
    output M_ACK, M_RDATA,
    input  GRANT_D, BUSY, ERR
  );

endinterface

// File: rtl/mem_port_arbiter_prio.sv
// Grant decision: D wins unless I has already waited through
// MAX_D_STREAK consecutive D grants, in which case I is forced.
module arb_priority_sel #(
  parameter int MAX_D_STREAK = 4,
  parameter int STRK_W       = 3
) (
  input  logic              i_req,
  input  logic              d_req,
  input  logic [STRK_W-1:0] d_streak,
  output logic              grant_d,
  output logic              grant_any
);

  localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(MAX_D_STREAK);

  // Pure combinational pick; registered by the top on the grant edge.
  always_comb begin
    grant_any = i_req | d_req;
    grant_d   = d_req & (~i_req | (d_streak < STRK_MAX));
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-ported memory between instruction fetch (I) and data (D).
// One transaction in flight; D has priority with a bounded I starvation
// guard; an optional watchdog aborts accesses the memory never acknowledges.
// Every output comes straight from a flop.
import mem_arb_pkg::*;

module mem_port_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT_CYC  = 64,
  parameter int CNT_W        = 8
) (
  input  logic               CLK,
  input  logic               RESET_N,
  mem_port_arbiter_if.slave  bus
);

  localparam int STRK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(MAX_D_STREAK);
  localparam logic [CNT_W-1:0]  TC_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam bit                WDOG_EN  = (TIMEOUT_CYC != 0);

  arb_state_t        state;
  logic [STRK_W-1:0] d_streak;
  logic [CNT_W-1:0]  tcnt;

  mem_req_t    m_q;
  logic        m_req_q;
  logic        grant_d_q;
  logic        busy_q;
  logic        err_q;
  logic        i_ack_q;
  logic        d_ack_q;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;

  mem_req_t    d_fields;
  mem_req_t    i_fields;
  logic        grant_d;
  logic        grant_any;
  logic        timeout_hit;

  // Candidate requests as they would be presented to memory.
  always_comb begin
    d_fields.we    = bus.D_WE;
    d_fields.addr  = bus.D_ADDR;
    d_fields.wdata = bus.D_WDATA;
    d_fields.size  = bus.D_SIZE;
    d_fields.sign  = bus.D_SIGN;
    i_fields       = ifetch_req(bus.I_ADDR);
    timeout_hit    = WDOG_EN && (tcnt == TC_LAST);
  end

  arb_priority_sel #(
    .MAX_D_STREAK (MAX_D_STREAK),
    .STRK_W       (STRK_W)
  ) u_sel (
    .i_req     (bus.I_REQ),
    .d_req     (bus.D_REQ),
    .d_streak  (d_streak),
    .grant_d   (grant_d),
    .grant_any (grant_any)
  );

  // Arbiter FSM with registered memory-side and requester-side outputs.
  // ACK/ERR are loaded on the ISSUE->RESP edge so they are high exactly
  // for the RESP cycle, then fall back to 0 by default.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      d_streak  <= '0;
      tcnt      <= '0;
      m_q       <= '0;
      m_req_q   <= 1'b0;
      grant_d_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            m_q       <= grant_d ? d_fields : i_fields;
            m_req_q   <= 1'b1;
            grant_d_q <= grant_d;
            busy_q    <= 1'b1;
            state     <= ISSUE;
            // Streak only grows while I is actually being held off.
            if (grant_d && bus.I_REQ) begin
              if (d_streak != STRK_MAX) d_streak <= d_streak + 1'b1;
            end else begin
              d_streak <= '0;
            end
          end
        end
        ISSUE: begin
          tcnt <= tcnt + 1'b1;
          if (bus.M_ACK) begin
            // An ACK on the watchdog's last cycle still counts as success.
            m_req_q <= 1'b0;
            state   <= RESP;
            if (grant_d_q) begin
              d_rdata_q <= bus.M_RDATA;
              d_ack_q   <= 1'b1;
            end else begin
              i_rdata_q <= bus.M_RDATA;
              i_ack_q   <= 1'b1;
            end
          end else if (timeout_hit) begin
            m_req_q <= 1'b0;
            err_q   <= 1'b1;
            state   <= RESP;
            if (grant_d_q) begin
              d_rdata_q <= '0;
              d_ack_q   <= 1'b1;
            end else begin
              i_rdata_q <= '0;
              i_ack_q   <= 1'b1;
            end
          end
        end
        RESP: begin
          tcnt      <= '0;
          busy_q    <= 1'b0;
          grant_d_q <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.M_REQ   = m_req_q;
  assign bus.M_WE    = m_q.we;
  assign bus.M_ADDR  = m_q.addr;
  assign bus.M_WDATA = m_q.wdata;
  assign bus.M_SIZE  = m_q.size;
  assign bus.M_SIGN  = m_q.sign;
  assign bus.I_ACK   = i_ack_q;
  assign bus.I_RDATA = i_rdata_q;
  assign bus.D_ACK   = d_ack_q;
  assign bus.D_RDATA = d_rdata_q;
  assign bus.GRANT_D = grant_d_q;
  assign bus.BUSY    = busy_q;
  assign bus.ERR     = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single transactions plus
// hand sequences for contention, starvation and reset mid-transaction.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  mem_port_arbiter_if bus();

  mem_port_arbiter #(
    .MAX_D_STREAK (4),
    .TIMEOUT_CYC  (8),
    .CNT_W        (8)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory model: ACK after mem_lat idle ISSUE cycles, never if !mem_en.
  int          mem_lat = 0;
  bit          mem_en = 1'b1;
  logic [31:0] mem_rdata = 32'h0;
  int          wait_cnt = 0;

  always @(posedge CLK) begin
    #1;
    if (bus.M_REQ && mem_en) begin
      if (wait_cnt == mem_lat) begin
        bus.M_ACK   = 1'b1;
        bus.M_RDATA = mem_rdata;
      end else begin
        bus.M_ACK   = 1'b0;
        bus.M_RDATA = 32'hBAD0BAD0;
      end
      wait_cnt++;
    end else begin
      bus.M_ACK   = 1'b0;
      bus.M_RDATA = 32'hBAD0BAD0;
      wait_cnt    = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    bit          is_d;
    mem_req_t    req;
    int          lat;
    bit          ack_en;
    logic [31:0] mdata;
    mem_req_t    exp_m;
    logic [31:0] exp_rdata;
    int          exp_issue;
    bit          exp_err;
  } vec_t;

  // One request from idle, observed until the owner's ACK.
  task automatic run_one(input vec_t v);
    int       iss = 0, other = 0, unstable = 0, ack_cyc = -1;
    bit       got = 0;
    logic     g = 1'b0, err_s = 1'b0;
    logic [31:0] rd = 32'h0;
    mem_req_t cap = '0, cur;
    mem_lat   = v.lat;
    mem_en    = v.ack_en;
    mem_rdata = v.mdata;
    bus.D_WE    = v.req.we;
    bus.D_WDATA = v.req.wdata;
    bus.D_SIZE  = v.req.size;
    bus.D_SIGN  = v.req.sign;
    if (v.is_d) begin bus.D_ADDR = v.req.addr; bus.D_REQ = 1'b1; end
    else        begin bus.I_ADDR = v.req.addr; bus.I_REQ = 1'b1; end
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge CLK);
      cur = '{bus.M_WE, bus.M_ADDR, bus.M_WDATA, bus.M_SIZE, bus.M_SIGN};
      if (bus.M_REQ) begin
        if (iss == 0) begin cap = cur; g = bus.GRANT_D; end
        else if (cur != cap) unstable++;
        iss++;
      end
      if (v.is_d ? bus.I_ACK : bus.D_ACK) other++;
      if (v.is_d ? bus.D_ACK : bus.I_ACK) begin
        got = 1; ack_cyc = c; err_s = bus.ERR;
        rd = v.is_d ? bus.D_RDATA : bus.I_RDATA;
      end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL %s ack_wait: no ACK within 100 cycles", v.name);
    end else begin
      chk({v.name, " grant_d"},  32'(g),               32'(v.is_d));
      chk({v.name, " m_we"},     32'(cap.we),          32'(v.exp_m.we));
      chk({v.name, " m_addr"},   cap.addr,             v.exp_m.addr);
      chk({v.name, " m_wdata"},  cap.wdata,            v.exp_m.wdata);
      chk({v.name, " m_size"},   32'(cap.size),        32'(v.exp_m.size));
      chk({v.name, " m_sign"},   32'(cap.sign),        32'(v.exp_m.sign));
      chk({v.name, " issue_cyc"}, 32'(iss),            32'(v.exp_issue));
      chk({v.name, " ack_cyc"},  32'(ack_cyc),         32'(v.exp_issue + 1));
      chk({v.name, " rdata"},    rd,                   v.exp_rdata);
      chk({v.name, " err"},      32'(err_s),           32'(v.exp_err));
      chk({v.name, " other_ack"}, 32'(other),          32'd0);
      chk({v.name, " m_stable"}, 32'(unstable),        32'd0);
    end
    @(posedge CLK); #1;
    bus.I_REQ = 1'b0;
    bus.D_REQ = 1'b0;
    @(negedge CLK);
    chk({v.name, " ack_pulse"}, 32'({bus.I_ACK, bus.D_ACK, bus.ERR}), 32'd0);
    @(posedge CLK); #1;
  endtask

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL global_time_limit: bench did not finish");
    $fatal(1);
  end

  initial begin
    int dc, ic, ng;
    bit first_seen, d_done, i_done, prev_mreq;
    logic gd_first, we_first;
    logic [31:0] wd_first, ad_first;
    logic [3:0] order;
    vec_t vr;

    vecs[0] = '{"i_fetch",   1'b0, '{1'b1, 32'h100,  32'hFFFF, SZ_BYTE, 1'b1}, 0, 1'b1, 32'hDEADBEEF,
                '{1'b0, 32'h100,  32'h0,  SZ_WORD, 1'b0}, 32'hDEADBEEF, 1, 1'b0};
    vecs[1] = '{"d_rd_word", 1'b1, '{1'b0, 32'h3000, 32'h0,    SZ_WORD, 1'b0}, 0, 1'b1, 32'hCAFEF00D,
                '{1'b0, 32'h3000, 32'h0,  SZ_WORD, 1'b0}, 32'hCAFEF00D, 1, 1'b0};
    vecs[2] = '{"d_wr_byte", 1'b1, '{1'b1, 32'h3003, 32'hAB,   SZ_BYTE, 1'b0}, 2, 1'b1, 32'h11111111,
                '{1'b1, 32'h3003, 32'hAB, SZ_BYTE, 1'b0}, 32'h11111111, 3, 1'b0};
    vecs[3] = '{"d_rd_half", 1'b1, '{1'b0, 32'h3002, 32'h0,    SZ_HALF, 1'b1}, 1, 1'b1, 32'h0000BEEF,
                '{1'b0, 32'h3002, 32'h0,  SZ_HALF, 1'b1}, 32'h0000BEEF, 2, 1'b0};
    vecs[4] = '{"d_lat5",    1'b1, '{1'b0, 32'h4000, 32'h0,    SZ_WORD, 1'b0}, 5, 1'b1, 32'h12345678,
                '{1'b0, 32'h4000, 32'h0,  SZ_WORD, 1'b0}, 32'h12345678, 6, 1'b0};
    vecs[5] = '{"i_lat3",    1'b0, '{1'b0, 32'h104,  32'h0,    SZ_WORD, 1'b0}, 3, 1'b1, 32'h00A00093,
                '{1'b0, 32'h104,  32'h0,  SZ_WORD, 1'b0}, 32'h00A00093, 4, 1'b0};
    vecs[6] = '{"d_timeout", 1'b1, '{1'b0, 32'h5000, 32'h0,    SZ_WORD, 1'b0}, 0, 1'b0, 32'h0,
                '{1'b0, 32'h5000, 32'h0,  SZ_WORD, 1'b0}, 32'h0,        8, 1'b1};
    vecs[7] = '{"d_after_to", 1'b1, '{1'b0, 32'h5004, 32'h0,   SZ_WORD, 1'b0}, 0, 1'b1, 32'h0BADF00D,
                '{1'b0, 32'h5004, 32'h0,  SZ_WORD, 1'b0}, 32'h0BADF00D, 1, 1'b0};
    vecs[8] = '{"i_timeout", 1'b0, '{1'b0, 32'h108,  32'h0,    SZ_WORD, 1'b0}, 0, 1'b0, 32'h0,
                '{1'b0, 32'h108,  32'h0,  SZ_WORD, 1'b0}, 32'h0,        8, 1'b1};

    bus.I_REQ = 0; bus.I_ADDR = 0;
    bus.D_REQ = 0; bus.D_WE = 0; bus.D_ADDR = 0; bus.D_WDATA = 0; bus.D_SIZE = 0; bus.D_SIGN = 0;

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst m_req",   32'(bus.M_REQ),   32'd0);
    chk("rst busy",    32'(bus.BUSY),    32'd0);
    chk("rst grant_d", 32'(bus.GRANT_D), 32'd0);
    chk("rst acks",    32'({bus.I_ACK, bus.D_ACK, bus.ERR}), 32'd0);
    chk("rst m_addr",  bus.M_ADDR,       32'd0);
    chk("rst rdata",   bus.I_RDATA | bus.D_RDATA, 32'd0);
    @(posedge CLK); #1;
    RESET_N = 1'b1;

    foreach (vecs[k]) run_one(vecs[k]);

    // Contention: D write wins, I follows three cycles after D's ACK.
    mem_lat = 0; mem_en = 1; mem_rdata = 32'h77;
    bus.D_WE = 1; bus.D_ADDR = 32'h2000; bus.D_WDATA = 32'h55; bus.D_SIZE = SZ_WORD; bus.D_SIGN = 0;
    bus.I_ADDR = 32'h200;
    bus.D_REQ = 1; bus.I_REQ = 1;
    dc = -1; ic = -1; first_seen = 0; d_done = 0; i_done = 0;
    gd_first = 0; we_first = 0; wd_first = 0; ad_first = 0;
    for (int c = 0; c < 60 && !(d_done && i_done); c++) begin
      @(negedge CLK);
      if (bus.M_REQ && !first_seen) begin
        first_seen = 1; gd_first = bus.GRANT_D; we_first = bus.M_WE;
        wd_first = bus.M_WDATA; ad_first = bus.M_ADDR;
      end
      if (bus.D_ACK) begin dc = c; chk("cont d_rdata", bus.D_RDATA, 32'h77); end
      if (bus.I_ACK) begin ic = c; chk("cont i_rdata", bus.I_RDATA, 32'h77); end
      @(posedge CLK); #1;
      if (dc >= 0 && !d_done) begin d_done = 1; bus.D_REQ = 0; end
      if (ic >= 0 && !i_done) begin i_done = 1; bus.I_REQ = 0; end
    end
    chk("cont first_grant_d", 32'(gd_first), 32'd1);
    chk("cont m_we",          32'(we_first), 32'd1);
    chk("cont m_wdata",       wd_first,      32'h55);
    chk("cont m_addr",        ad_first,      32'h2000);
    chk("cont i_after_d",     32'(ic - dc),  32'd3);
    @(posedge CLK); #1;

    // Starvation guard: D,D,D,D,I,D with both held.
    bus.D_WE = 0; bus.D_ADDR = 32'h7000; bus.D_SIZE = SZ_WORD;
    bus.I_ADDR = 32'h300;
    bus.D_REQ = 1; bus.I_REQ = 1;
    ng = 0; order = '0; prev_mreq = 0;
    for (int c = 0; c < 200 && (bus.D_REQ || bus.I_REQ); c++) begin
      @(negedge CLK);
      if (bus.M_REQ && !prev_mreq) begin
        if (ng < 4) order[ng] = bus.GRANT_D;
        else if (ng == 4) chk("starve grant5_is_i", 32'(bus.GRANT_D), 32'd0);
        else if (ng == 5) chk("starve grant6_is_d", 32'(bus.GRANT_D), 32'd1);
        ng++;
      end
      prev_mreq = bus.M_REQ;
      d_done = bus.D_ACK; i_done = bus.I_ACK;
      @(posedge CLK); #1;
      if (d_done) begin
        if (ng >= 6) bus.D_REQ = 0;
        else bus.D_ADDR = bus.D_ADDR + 32'd4;
      end
      if (i_done) bus.I_REQ = 0;
    end
    chk("starve first4_d", 32'(order), 32'hF);
    chk("starve n_grants", 32'(ng),    32'd6);
    @(posedge CLK); #1;

    // Reset during ISSUE: outputs drop without a clock, no ACK afterwards.
    mem_en = 0;
    bus.D_WE = 0; bus.D_ADDR = 32'h6000;
    bus.D_REQ = 1;
    repeat (3) @(negedge CLK);
    chk("rstmid pre m_req", 32'(bus.M_REQ), 32'd1);
    #2 RESET_N = 1'b0;
    #1;
    chk("rstmid m_req",   32'(bus.M_REQ),   32'd0);
    chk("rstmid busy",    32'(bus.BUSY),    32'd0);
    chk("rstmid grant_d", 32'(bus.GRANT_D), 32'd0);
    bus.D_REQ = 0;
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    mem_en = 1;
    dc = 0;
    repeat (5) begin
      @(negedge CLK);
      if (bus.I_ACK || bus.D_ACK || bus.ERR || bus.M_REQ) dc++;
    end
    chk("rstmid no_ack", 32'(dc), 32'd0);
    @(posedge CLK); #1;
    vr = '{"i_after_rst", 1'b0, '{1'b0, 32'h400, 32'h0, SZ_WORD, 1'b0}, 0, 1'b1, 32'h13579BDF,
           '{1'b0, 32'h400, 32'h0, SZ_WORD, 1'b0}, 32'h13579BDF, 1, 1'b0};
    run_one(vr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported backing memory between the pipeline's instruction-fetch requester (I) and data-memory requester (D).
- Sits between the OTTER fetch/memory stages and a variable-latency memory with a req/ack handshake.
- Serialises accesses with one outstanding transaction at a time.
- Gives D priority, with a bounded starvation guard for I, and a timeout watchdog.

Parameters:
- MAX_D_STREAK, 4: consecutive D grants allowed while I is waiting before I is forced.
- TIMEOUT_CYC, 64: cycles in ISSUE without M_ACK before abort. 0 disables the watchdog.
- CNT_W, 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- CLK  in  1  system clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- I_REQ  in  1  fetch request, held until I_ACK
- I_ADDR  in  32  fetch byte address
- I_ACK  out  1  one-cycle completion pulse for fetch
- I_RDATA  out  32  fetch data, valid while I_ACK=1
- D_REQ  in  1  data request, held until D_ACK
- D_WE  in  1  1 = write, 0 = read
- D_ADDR  in  32  data byte address
- D_WDATA  in  32  write data
- D_SIZE  in  2  00 byte, 01 half, 10 word
- D_SIGN  in  1  1 = zero-extend on load (unsigned)
- D_ACK  out  1  one-cycle completion pulse for data
- D_RDATA  out  32  load data, valid while D_ACK=1
- M_REQ  out  1  memory request, held until M_ACK
- M_WE, M_ADDR, M_WDATA, M_SIZE, M_SIGN  out  1/32/32/2/1  registered copy of the granted request (I grant: WE=0, SIZE=10, SIGN=0, WDATA=0)
- M_ACK  in  1  memory completion, may assert the first cycle M_REQ=1
- M_RDATA  in  32  read data, valid with M_ACK
- GRANT_D  out  1  owner of the current transaction (1 = D, 0 = I)
- BUSY  out  1  state != IDLE
- ERR  out  1  one-cycle pulse coincident with the ACK of a timed-out transaction

Behaviour:
- Reset (async, RESET_N=0): state=IDLE. All outputs 0. d_streak=0, tcnt=0. An in-flight transaction is abandoned: M_REQ drops immediately and no ACK is issued after reset release.
- All outputs are registered. No combinational path from any input to any output.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If D_REQ and (!I_REQ or d_streak<MAX_D_STREAK): grant D.
  - Else if I_REQ: grant I.
  - On grant: latch request fields into M_*, set M_REQ=1 and GRANT_D, go to ISSUE at the next edge.
  - No request: stay in IDLE.
- Starvation counter:
  - D grant with I_REQ=1: d_streak increments, saturating at MAX_D_STREAK.
  - D grant with I_REQ=0: d_streak clears.
  - I grant: d_streak clears.
- ISSUE:
  - Hold M_* stable and increment tcnt.
  - On M_ACK=1: capture M_RDATA into the owner's RDATA register, M_REQ=0, go to RESP.
  - If TIMEOUT_CYC!=0 and tcnt==TIMEOUT_CYC-1 with no M_ACK: M_REQ=0, RDATA=0, arm ERR, go to RESP.
  - M_ACK on the timeout cycle counts as success.
- RESP: exactly one cycle.
  - Owner's ACK=1 with RDATA valid. ERR=1 if armed.
  - The non-owner's ACK stays 0.
  - Clears tcnt, returns to IDLE.
- RDATA registers hold their last value after ACK. Consumers must qualify with ACK.
- Requester rules: REQ and fields must stay stable from assertion through the ACK cycle. A new request may be presented from the cycle after ACK. Changes while not acknowledged are a protocol violation; no checking is required.
- Minimum turnaround: grant cycle, M_ACK cycle, RESP cycle = 3 cycles per access. Back-to-back accesses therefore complete at most every 3 cycles.
- Writes complete the same way; the owner's RDATA is M_RDATA (don't-care to the requester).
- M_ACK outside ISSUE is ignored.

Decomposition:
- Shared package mem_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t
  - size constants SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
  - typedef struct mem_req_t {we, addr, wdata, size, sign}
- One sub-module, arb_priority_sel: combinational D-priority plus streak decision, producing grant_d and grant_any. Everything else stays in the top.

Test Plan:
- I only: I_REQ=1, I_ADDR=0x100, M_ACK asserted the cycle after M_REQ with M_RDATA=0xDEADBEEF -> M_ADDR=0x100, M_WE=0, M_SIZE=10; I_ACK pulses 1 cycle with I_RDATA=0xDEADBEEF; D_ACK=0.
- Contention: I_REQ and D_REQ both 1 in IDLE, D_WE=1, D_ADDR=0x2000, D_WDATA=0x55 -> D granted first (GRANT_D=1, M_WE=1, M_WDATA=0x55); I served next; I_ACK exactly 3 cycles after D_ACK with 1-cycle memory latency.
- Starvation: I_REQ held, D_REQ held with new addresses each ACK, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,...
- Timeout: TIMEOUT_CYC=8, D read, M_ACK never asserted -> M_REQ drops after 8 ISSUE cycles; D_ACK=1, ERR=1, D_RDATA=0 in the same cycle; next request proceeds normally.
- Reset mid-transaction: RESET_N=0 during ISSUE -> M_REQ, BUSY, GRANT_D go 0 immediately without waiting for a clock edge; after release, no ACK is issued and a fresh I_REQ is served normally.
- Variable latency: M_ACK delayed 5 cycles on a D read returning 0x12345678 -> M_* stable for all 5 cycles; D_ACK pulses once with D_RDATA=0x12345678; ERR=0.
